// File: rtl/atf_config_loader_if.sv
// Configuration command stream between the CMS configuration path and the trace-filter loader.
// The CMS side owns the master modport and the loader owns the slave modport.
interface atf_config_loader_if;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/atf_config_loader.sv
// Configuration loader for the advanced trace filter.
// Parses header/payload words from the command stream, assembles seeds and bound pairs,
// and issues single-cycle seed/range write strobes. A clear-all command walks every slot
// back to its default (seed = 0, lower = 0, upper = all-ones).
module atf_config_loader #(
    parameter int DETERMINISTIC_DATA_WIDTH = 1024,
    parameter int NUM_OF_SEEDS             = 2,
    parameter int RANGES_PER_SEED          = 2,
    parameter int SEED_ADDR_WIDTH          = 1,
    parameter int RANGE_ADDR_WIDTH         = 1,
    parameter int BOUNDS_WIDTH             = 11
) (
    input  logic                                clk,
    input  logic                                rst_n,
    atf_config_loader_if.slave                  cfg,
    input  logic                                err_clear,
    output logic [DETERMINISTIC_DATA_WIDTH-1:0] seed_input,
    output logic [SEED_ADDR_WIDTH-1:0]          seed_input_address,
    output logic                                seed_write_enable,
    output logic [BOUNDS_WIDTH-1:0]             lower_bound_input,
    output logic [BOUNDS_WIDTH-1:0]             upper_bound_input,
    output logic [SEED_ADDR_WIDTH-1:0]          range_input_seed_address,
    output logic [RANGE_ADDR_WIDTH-1:0]         range_input_range_address,
    output logic                                range_write_enable,
    output logic                                busy,
    output logic                                err_sticky
);

    localparam int WORDS = DETERMINISTIC_DATA_WIDTH / 32;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_SEED_LOAD    = 3'd1;
    localparam logic [2:0] ST_RANGE_LOAD   = 3'd2;
    localparam logic [2:0] ST_DRAIN        = 3'd3;
    localparam logic [2:0] ST_COMMIT       = 3'd4;
    localparam logic [2:0] ST_CLEAR_SEEDS  = 3'd5;
    localparam logic [2:0] ST_CLEAR_RANGES = 3'd6;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SEED  = 2'b01;
    localparam logic [1:0] OP_RANGE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [2:0]                          state_q, state_d;
    logic [CNT_W-1:0]                    word_cnt_q, word_cnt_d;
    logic [1:0]                          op_q, op_d;
    logic [SEED_ADDR_WIDTH-1:0]          tgt_seed_q, tgt_seed_d;
    logic [RANGE_ADDR_WIDTH-1:0]         tgt_range_q, tgt_range_d;
    logic [DETERMINISTIC_DATA_WIDTH-1:0] seed_q, seed_d;
    logic [SEED_ADDR_WIDTH-1:0]          seed_addr_q, seed_addr_d;
    logic [BOUNDS_WIDTH-1:0]             lower_q, lower_d;
    logic [BOUNDS_WIDTH-1:0]             upper_q, upper_d;
    logic [SEED_ADDR_WIDTH-1:0]          rng_seed_q, rng_seed_d;
    logic [RANGE_ADDR_WIDTH-1:0]         rng_addr_q, rng_addr_d;
    logic                                err_q, err_d;
    logic                                ready_en_q, ready_en_d;

    logic                    hs;
    logic [1:0]              hdr_op;
    logic [7:0]              hdr_seed;
    logic [7:0]              hdr_range;
    logic                    seed_bad;
    logic                    range_bad;
    logic                    last_word;
    logic [BOUNDS_WIDTH-1:0] pay_lower;
    logic [BOUNDS_WIDTH-1:0] pay_upper;
    logic                    err_set;

    // Header/payload field extraction and address validation of the incoming word
    always_comb begin
        hs        = cfg.cfg_valid && cfg.cfg_ready;
        hdr_op    = cfg.cfg_data[31:30];
        hdr_seed  = cfg.cfg_data[15:8];
        hdr_range = cfg.cfg_data[7:0];
        seed_bad  = (32'(hdr_seed) >= 32'(NUM_OF_SEEDS));
        range_bad = (32'(hdr_range) >= 32'(RANGES_PER_SEED));
        last_word = (word_cnt_q == CNT_W'(WORDS - 1));
        pay_lower = cfg.cfg_data[BOUNDS_WIDTH-1:0];
        pay_upper = cfg.cfg_data[16 +: BOUNDS_WIDTH];
    end

    // Command state machine: header decode, payload assembly, commit and clear-all walk
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        op_d        = op_q;
        tgt_seed_d  = tgt_seed_q;
        tgt_range_d = tgt_range_q;
        seed_d      = seed_q;
        seed_addr_d = seed_addr_q;
        lower_d     = lower_q;
        upper_d     = upper_q;
        rng_seed_d  = rng_seed_q;
        rng_addr_d  = rng_addr_q;
        ready_en_d  = 1'b1;
        err_set     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    op_d        = hdr_op;
                    tgt_seed_d  = hdr_seed[SEED_ADDR_WIDTH-1:0];
                    tgt_range_d = hdr_range[RANGE_ADDR_WIDTH-1:0];
                    word_cnt_d  = '0;
                    case (hdr_op)
                        OP_SEED: begin
                            if (seed_bad) begin
                                err_set = 1'b1;
                                state_d = ST_DRAIN;
                            end else begin
                                state_d = ST_SEED_LOAD;
                            end
                        end
                        OP_RANGE: begin
                            if (seed_bad || range_bad) begin
                                err_set = 1'b1;
                                state_d = ST_DRAIN;
                            end else begin
                                state_d = ST_RANGE_LOAD;
                            end
                        end
                        OP_CLEAR: begin
                            state_d     = ST_CLEAR_SEEDS;
                            seed_d      = '0;
                            seed_addr_d = '0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_SEED_LOAD: begin
                if (hs) begin
                    seed_d[32*word_cnt_q +: 32] = cfg.cfg_data;
                    if (last_word) begin
                        seed_addr_d = tgt_seed_q;
                        state_d     = ST_COMMIT;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end

            ST_RANGE_LOAD: begin
                if (hs) begin
                    if (pay_lower > pay_upper) begin
                        err_set = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        lower_d    = pay_lower;
                        upper_d    = pay_upper;
                        rng_seed_d = tgt_seed_q;
                        rng_addr_d = tgt_range_q;
                        state_d    = ST_COMMIT;
                    end
                end
            end

            ST_DRAIN: begin
                if (hs) begin
                    if ((op_q != OP_SEED) || last_word) begin
                        state_d = ST_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
            end

            ST_CLEAR_SEEDS: begin
                if (seed_addr_q == SEED_ADDR_WIDTH'(NUM_OF_SEEDS - 1)) begin
                    state_d    = ST_CLEAR_RANGES;
                    rng_seed_d = '0;
                    rng_addr_d = '0;
                    lower_d    = '0;
                    upper_d    = '1;
                end else begin
                    seed_addr_d = seed_addr_q + 1'b1;
                end
            end

            ST_CLEAR_RANGES: begin
                if (rng_addr_q == RANGE_ADDR_WIDTH'(RANGES_PER_SEED - 1)) begin
                    if (rng_seed_q == SEED_ADDR_WIDTH'(NUM_OF_SEEDS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        rng_seed_d = rng_seed_q + 1'b1;
                        rng_addr_d = '0;
                    end
                end else begin
                    rng_addr_d = rng_addr_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A rejection in the same cycle as err_clear must leave the flag set
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and datapath registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            op_q        <= OP_NOP;
            tgt_seed_q  <= '0;
            tgt_range_q <= '0;
            seed_q      <= '0;
            seed_addr_q <= '0;
            lower_q     <= '0;
            upper_q     <= '0;
            rng_seed_q  <= '0;
            rng_addr_q  <= '0;
            err_q       <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            op_q        <= op_d;
            tgt_seed_q  <= tgt_seed_d;
            tgt_range_q <= tgt_range_d;
            seed_q      <= seed_d;
            seed_addr_q <= seed_addr_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            rng_seed_q  <= rng_seed_d;
            rng_addr_q  <= rng_addr_d;
            err_q       <= err_d;
            ready_en_q  <= ready_en_d;
        end
    end

    // Output decode: strobes come straight from the state so they last exactly one state cycle
    always_comb begin
        cfg.cfg_ready = ready_en_q &&
                        ((state_q == ST_IDLE) || (state_q == ST_SEED_LOAD) ||
                         (state_q == ST_RANGE_LOAD) || (state_q == ST_DRAIN));
        seed_write_enable  = ((state_q == ST_COMMIT) && (op_q == OP_SEED)) ||
                             (state_q == ST_CLEAR_SEEDS);
        range_write_enable = ((state_q == ST_COMMIT) && (op_q == OP_RANGE)) ||
                             (state_q == ST_CLEAR_RANGES);
        busy                      = (state_q != ST_IDLE);
        err_sticky                = err_q;
        seed_input                = seed_q;
        seed_input_address        = seed_addr_q;
        lower_bound_input         = lower_q;
        upper_bound_input         = upper_q;
        range_input_seed_address  = rng_seed_q;
        range_input_range_address = rng_addr_q;
    end

endmodule

// File: tb/tb_atf_config_loader.sv
// Self-checking bench for atf_config_loader: directed commands drive a command-level model
// that predicts every write strobe (cycle, kind, addresses, data) and the held outputs.
module tb_atf_config_loader;

    localparam int DW    = 1024;
    localparam int WORDS = DW / 32;
    localparam int NS    = 2;
    localparam int NR    = 2;
    localparam int SAW   = 1;
    localparam int RAW   = 1;
    localparam int BW    = 11;

    typedef struct {
        bit            is_range;
        int            cyc;
        int            sa;
        int            ra;
        logic [DW-1:0] seed;
        int            lo;
        int            hi;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           err_clear = 1'b0;
    logic [DW-1:0]  seed_input;
    logic [SAW-1:0] seed_input_address;
    logic           seed_write_enable;
    logic [BW-1:0]  lower_bound_input;
    logic [BW-1:0]  upper_bound_input;
    logic [SAW-1:0] range_input_seed_address;
    logic [RAW-1:0] range_input_range_address;
    logic           range_write_enable;
    logic           busy;
    logic           err_sticky;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ev_t           exp_q[$];
    ev_t           pend_ev;
    ev_t           cev;
    logic [31:0]   words[WORDS];
    logic [DW-1:0] m_seed;
    int            m_seed_addr;
    int            m_lo;
    int            m_hi;
    int            m_rseed;
    int            m_raddr;
    bit            m_err;

    atf_config_loader_if cfg_if ();

    atf_config_loader #(
        .DETERMINISTIC_DATA_WIDTH(DW),
        .NUM_OF_SEEDS(NS),
        .RANGES_PER_SEED(NR),
        .SEED_ADDR_WIDTH(SAW),
        .RANGE_ADDR_WIDTH(RAW),
        .BOUNDS_WIDTH(BW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg(cfg_if.slave),
        .err_clear(err_clear),
        .seed_input(seed_input),
        .seed_input_address(seed_input_address),
        .seed_write_enable(seed_write_enable),
        .lower_bound_input(lower_bound_input),
        .upper_bound_input(upper_bound_input),
        .range_input_seed_address(range_input_seed_address),
        .range_input_range_address(range_input_range_address),
        .range_write_enable(range_write_enable),
        .busy(busy),
        .err_sticky(err_sticky)
    );

    // Free-running clock and a cycle index that tags each rising edge
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scalar comparison with one FAIL line per mismatch
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Seed comparison that reports only the first differing 32-bit word
    task automatic check_seed(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < WORDS; k++) begin
                if (act[32*k +: 32] !== exp[32*k +: 32]) begin
                    $display("[TB] FAIL %s: word %0d got 0x%08h, required 0x%08h",
                             name, k, act[32*k +: 32], exp[32*k +: 32]);
                    break;
                end
            end
        end
    endtask

    // Held output registers against the model's last committed values
    task automatic check_held(input string tag);
        check_seed({tag, "_seed_input"}, seed_input, m_seed);
        check_output({tag, "_seed_addr"}, seed_input_address, m_seed_addr);
        check_output({tag, "_lower"}, lower_bound_input, m_lo);
        check_output({tag, "_upper"}, upper_bound_input, m_hi);
        check_output({tag, "_range_seed"}, range_input_seed_address, m_rseed);
        check_output({tag, "_range_addr"}, range_input_range_address, m_raddr);
        check_output({tag, "_err"}, err_sticky, m_err);
    endtask

    // Compare process: every strobe must match the head of the expected-event queue
    always begin
        @(posedge clk);
        #3;
        check_output("strobe_exclusive", seed_write_enable & range_write_enable, 0);
        if (seed_write_enable || range_write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got seed=%0b range=%0b at cycle %0d, required none",
                         seed_write_enable, range_write_enable, cyc);
            end else begin
                cev = exp_q.pop_front();
                check_output("strobe_cycle", cyc, cev.cyc);
                check_output("strobe_kind", range_write_enable, cev.is_range);
                if (!cev.is_range) begin
                    check_output("strobe_seed_addr", seed_input_address, cev.sa);
                    check_seed("strobe_seed_data", seed_input, cev.seed);
                end else begin
                    check_output("strobe_range_seed", range_input_seed_address, cev.sa);
                    check_output("strobe_range_addr", range_input_range_address, cev.ra);
                    check_output("strobe_lower", lower_bound_input, cev.lo);
                    check_output("strobe_upper", upper_bound_input, cev.hi);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_strobe: got no strobe at cycle %0d, required one at cycle %0d",
                     cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    // Send one word with optional random idle cycles; mode 1 expects a commit strobe,
    // mode 2 expects the full clear-all walk, both starting the cycle after the handshake edge
    task automatic apply_stimulus(input logic [31:0] d, input int mode, input int max_stall);
        int n;
        int p;
        ev_t e;
        cfg_if.cfg_valid = 1'b0;
        repeat ($urandom_range(0, max_stall)) @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        n = 0;
        while (!cfg_if.cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_if.cfg_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got cfg_ready=0 for 200 cycles, required 1");
            cfg_if.cfg_valid = 1'b0;
            return;
        end
        p = cyc + 1;
        if (mode == 1) begin
            e = pend_ev;
            e.cyc = p;
            exp_q.push_back(e);
        end else if (mode == 2) begin
            for (int i = 0; i < NS; i++) begin
                e = '{is_range: 1'b0, cyc: p + i, sa: i, ra: 0, seed: '0, lo: 0, hi: 0};
                exp_q.push_back(e);
            end
            for (int j = 0; j < NS * NR; j++) begin
                e = '{is_range: 1'b1, cyc: p + NS + j, sa: j / NR, ra: j % NR, seed: '0,
                      lo: 0, hi: (1 << BW) - 1};
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Seed command: header plus WORDS payload words taken from words[]
    task automatic run_seed_cmd(input logic [31:0] hdr, input int max_stall);
        int sa;
        logic [DW-1:0] s;
        sa = int'(hdr[15:8]);
        for (int k = 0; k < WORDS; k++) s[32*k +: 32] = words[k];
        apply_stimulus(hdr, 0, max_stall);
        if (sa >= NS) begin
            m_err = 1'b1;
            for (int k = 0; k < WORDS; k++) apply_stimulus(words[k], 0, max_stall);
        end else begin
            pend_ev = '{is_range: 1'b0, cyc: 0, sa: sa, ra: 0, seed: s, lo: 0, hi: 0};
            for (int k = 0; k < WORDS - 1; k++) apply_stimulus(words[k], 0, max_stall);
            apply_stimulus(words[WORDS-1], 1, max_stall);
            m_seed      = s;
            m_seed_addr = sa;
        end
    endtask

    // Range command: header plus one bounds word
    task automatic run_range_cmd(input logic [31:0] hdr, input logic [31:0] payload);
        int sa;
        int ra;
        int lo;
        int hi;
        sa = int'(hdr[15:8]);
        ra = int'(hdr[7:0]);
        lo = int'(payload[BW-1:0]);
        hi = int'(payload[16 +: BW]);
        apply_stimulus(hdr, 0, 0);
        if (sa >= NS || ra >= NR || lo > hi) begin
            m_err = 1'b1;
            apply_stimulus(payload, 0, 0);
        end else begin
            pend_ev = '{is_range: 1'b1, cyc: 0, sa: sa, ra: ra, seed: '0, lo: lo, hi: hi};
            apply_stimulus(payload, 1, 0);
            m_lo    = lo;
            m_hi    = hi;
            m_rseed = sa;
            m_raddr = ra;
        end
    endtask

    // One-cycle err_clear pulse
    task automatic pulse_err_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_err = 1'b0;
        check_output("err_after_clear", err_sticky, 0);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence
    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        m_seed = '0; m_seed_addr = 0; m_lo = 0; m_hi = 0; m_rseed = 0; m_raddr = 0; m_err = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_ready", cfg_if.cfg_ready, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_strobes", {seed_write_enable, range_write_enable}, 0);
        check_held("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("ready_after_reset", cfg_if.cfg_ready, 1);

        $display("[TB] seed load without stalls");
        for (int k = 0; k < WORDS; k++) words[k] = 32'(k);
        run_seed_cmd(32'h4000_0100, 0);
        @(negedge clk);
        check_output("seed_word0_literal", seed_input[31:0], 32'h0000_0000);
        check_output("seed_word31_literal", seed_input[1023:992], 32'h0000_001F);
        check_output("seed_addr_literal", seed_input_address, 1);
        check_held("seed");

        $display("[TB] range load");
        run_range_cmd(32'h8000_0001, 32'h0190_0064);
        @(negedge clk);
        check_output("range_lower_literal", lower_bound_input, 100);
        check_output("range_upper_literal", upper_bound_input, 400);
        check_output("range_seed_literal", range_input_seed_address, 0);
        check_output("range_addr_literal", range_input_range_address, 1);
        check_held("range");

        $display("[TB] rejected seed address");
        run_seed_cmd(32'h4000_0500, 0);
        @(negedge clk);
        check_output("seed_reject_err_literal", err_sticky, 1);
        check_output("seed_reject_idle", busy, 0);
        check_held("seed_reject");
        pulse_err_clear();

        $display("[TB] rejected bounds order");
        run_range_cmd(32'h8000_0001, 32'h0010_0020);
        @(negedge clk);
        check_output("bounds_reject_err_literal", err_sticky, 1);
        check_held("bounds_reject");
        pulse_err_clear();

        $display("[TB] rejected range address");
        run_range_cmd(32'h8000_0003, 32'h0005_0001);
        @(negedge clk);
        check_held("range_addr_reject");
        pulse_err_clear();

        apply_stimulus(32'h0000_0000, 0, 0);
        check_output("nop_stays_idle", busy, 0);

        $display("[TB] clear all");
        apply_stimulus(32'hC000_0000, 2, 0);
        m_seed = '0; m_seed_addr = NS - 1; m_rseed = NS - 1; m_raddr = NR - 1;
        m_lo = 0; m_hi = (1 << BW) - 1;
        for (int i = 0; i < NS + NS * NR; i++) begin
            check_output("clear_ready_low", cfg_if.cfg_ready, 0);
            check_output("clear_busy_high", busy, 1);
            @(negedge clk);
        end
        check_output("clear_done_ready", cfg_if.cfg_ready, 1);
        check_output("clear_done_busy", busy, 0);
        check_output("clear_upper_literal", upper_bound_input, 11'h7FF);
        check_output("clear_lower_literal", lower_bound_input, 0);
        check_held("clear");

        $display("[TB] seed load with random stalls");
        for (int k = 0; k < WORDS; k++) words[k] = 32'(k);
        run_seed_cmd(32'h4000_0100, 3);
        @(negedge clk);
        check_output("stall_word31_literal", seed_input[1023:992], 32'h0000_001F);
        check_output("stall_word17_literal", seed_input[575:544], 32'h0000_0011);
        check_held("stall");

        $display("[TB] reset during seed load");
        for (int k = 0; k < WORDS; k++) words[k] = 32'hA5A5_0000 + 32'(k);
        apply_stimulus(32'h4000_0000, 0, 0);
        for (int k = 0; k <= 10; k++) apply_stimulus(words[k], 0, 0);
        rst_n = 1'b0;
        #1;
        m_seed = '0; m_seed_addr = 0; m_lo = 0; m_hi = 0; m_rseed = 0; m_raddr = 0; m_err = 1'b0;
        check_output("midreset_ready", cfg_if.cfg_ready, 0);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_strobes", {seed_write_enable, range_write_enable}, 0);
        check_held("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seed_cmd(32'h4000_0000, 0);
        @(negedge clk);
        check_output("post_reset_word1_literal", seed_input[63:32], 32'hA5A5_0001);
        check_held("post_reset");

        repeat (3) @(negedge clk);
        check_output("pending_events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
